// File: rtl/vga_pixel_pipe_if.sv
// Pixel-pipe bus: timing/pattern inputs from the VGA timing stages and
// DAC-facing outputs back out.
//   master : drives column/row/syncs/rgb_en/mode/solid_rgb, observes the outputs
//   slave  : the pixel pipe itself
interface vga_pixel_pipe_if;
  logic [9:0]  column;
  logic [9:0]  row;
  logic        hsync;
  logic        vsync;
  logic        rgb_en;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [7:0]  frame_cnt;

  modport master (
    output column, row, hsync, vsync, rgb_en, mode, solid_rgb,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_cnt
  );

  modport slave (
    input  column, row, hsync, vsync, rgb_en, mode, solid_rgb,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_cnt
  );
endinterface

// File: rtl/vga_pixel_pipe.sv
// Two-stage VGA test-pattern pixel pipe.
// Stage 1 evaluates visibility and the selected pattern for the current
// column/row; stage 2 registers colour and syncs for the DAC.
// Ports:
//   clk  : pixel clock, one pixel per rising edge
//   rst  : asynchronous active-low reset
//   bus  : vga_pixel_pipe_if.slave (column, row, hsync, vsync, rgb_en,
//          mode, solid_rgb in; vga_r/g/b, vga_hsync, vga_vsync, frame_cnt out)
// Patterns: 0 solid, 1 colour bars, 2 scrolling checkerboard,
//           3 border/crosshair. mode is latched only at frame start.
module vga_pixel_pipe #(
  parameter int unsigned H_VIS     = 640,
  parameter int unsigned V_VIS     = 480,
  parameter int unsigned CELL_LOG2 = 5
) (
  input  logic            clk,
  input  logic            rst,
  vga_pixel_pipe_if.slave bus
);

  localparam int unsigned CW    = 10;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned FC_W  = 8;

  localparam logic [CW-1:0] H_END  = CW'(H_VIS);
  localparam logic [CW-1:0] V_END  = CW'(V_VIS);
  localparam logic [CW-1:0] H_LAST = CW'(H_VIS - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_VIS - 1);
  localparam logic [CW-1:0] H_MID  = CW'(H_VIS / 2);
  localparam logic [CW-1:0] V_MID  = CW'(V_VIS / 2);

  localparam logic [1:0] MODE_SOLID  = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_BORDER = 2'd3;

  localparam logic [RGB_W-1:0] WHITE = 12'hFFF;
  localparam logic [RGB_W-1:0] BLACK = 12'h000;

  // Bar index = column/80 via a compare chain (no divider).
  function automatic logic [2:0] bar_index(input logic [CW-1:0] col);
    logic [2:0] idx;
    if      (col < 10'd80)  idx = 3'd0;
    else if (col < 10'd160) idx = 3'd1;
    else if (col < 10'd240) idx = 3'd2;
    else if (col < 10'd320) idx = 3'd3;
    else if (col < 10'd400) idx = 3'd4;
    else if (col < 10'd480) idx = 3'd5;
    else if (col < 10'd560) idx = 3'd6;
    else                    idx = 3'd7;
    return idx;
  endfunction

  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // State
  logic             origin_q;
  logic [1:0]       mode_q;
  logic [FC_W-1:0]  frame_cnt_q;
  logic [RGB_W-1:0] s1_rgb_q;
  logic             s1_hsync_q;
  logic             s1_vsync_q;
  logic [RGB_W-1:0] out_rgb_q;
  logic             out_hsync_q;
  logic             out_vsync_q;

  // Stage-1 combinational terms
  logic             at_origin_c;
  logic             frame_start_c;
  logic             active_c;
  logic             checker_c;
  logic             border_c;
  logic [RGB_W-1:0] pattern_c;

  // Frame start is the rising edge of the (0,0) condition, so a held origin pulses once.
  assign at_origin_c   = (bus.row == '0) && (bus.column == '0);
  assign frame_start_c = at_origin_c && !origin_q;

  assign active_c = bus.rgb_en && (bus.column < H_END) && (bus.row < V_END);

  // Only bit CELL_LOG2 of the 10-bit wrapped scroll sum matters.
  assign checker_c = 1'((bus.column + CW'(frame_cnt_q)) >> CELL_LOG2)
                   ^ 1'(bus.row >> CELL_LOG2);

  assign border_c = (bus.column == '0) || (bus.column == H_LAST) || (bus.column == H_MID)
                 || (bus.row == '0)    || (bus.row == V_LAST)    || (bus.row == V_MID);

  // Pattern select uses the mode latched at the last frame start.
  always_comb begin
    pattern_c = BLACK;
    case (mode_q)
      MODE_SOLID:  pattern_c = bus.solid_rgb;
      MODE_BARS:   pattern_c = bar_colour(bar_index(bus.column));
      MODE_CHECK:  pattern_c = checker_c ? WHITE : BLACK;
      MODE_BORDER: pattern_c = border_c ? WHITE : BLACK;
      default:     pattern_c = BLACK;
    endcase
  end

  // Frame bookkeeping plus both pipeline stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      origin_q    <= 1'b0;
      mode_q      <= MODE_SOLID;
      frame_cnt_q <= '0;
      s1_rgb_q    <= BLACK;
      s1_hsync_q  <= 1'b1;
      s1_vsync_q  <= 1'b1;
      out_rgb_q   <= BLACK;
      out_hsync_q <= 1'b1;
      out_vsync_q <= 1'b1;
    end else begin
      origin_q <= at_origin_c;
      if (frame_start_c) begin
        mode_q      <= bus.mode;
        frame_cnt_q <= FC_W'(frame_cnt_q + 8'd1);
      end
      s1_rgb_q    <= active_c ? pattern_c : BLACK;
      s1_hsync_q  <= bus.hsync;
      s1_vsync_q  <= bus.vsync;
      out_rgb_q   <= s1_rgb_q;
      out_hsync_q <= s1_hsync_q;
      out_vsync_q <= s1_vsync_q;
    end
  end

  assign bus.vga_r     = out_rgb_q[11:8];
  assign bus.vga_g     = out_rgb_q[7:4];
  assign bus.vga_b     = out_rgb_q[3:0];
  assign bus.vga_hsync = out_hsync_q;
  assign bus.vga_vsync = out_vsync_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe: reset, latency/sync alignment, colour
// bars, mode latching, checkerboard scroll and frame counter wrap.
module tb_vga_pixel_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pixel_pipe_if bus ();

  vga_pixel_pipe #(
    .H_VIS    (640),
    .V_VIS    (480),
    .CELL_LOG2(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb_out();
    return {bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel, hold it through both stages, then check the colour.
  task automatic pix(input int col, input int r, input string tag, input logic [11:0] exp);
    bus.column = 10'(col);
    bus.row    = 10'(r);
    tick();
    tick();
    check(tag, 32'(rgb_out()), 32'(exp));
  endtask

  // Leave the origin and come back to it: one frame-start pulse.
  task automatic next_frame();
    bus.column = 10'd0;
    bus.row    = 10'd1;
    tick();
    bus.row    = 10'd0;
    tick();
  endtask

  logic hs_prev;

  initial begin
    rst           = 1'b0;
    bus.column    = 10'd0;
    bus.row       = 10'd10;
    bus.hsync     = 1'b1;
    bus.vsync     = 1'b1;
    bus.rgb_en    = 1'b1;
    bus.mode      = 2'd0;
    bus.solid_rgb = 12'hA5C;
    hs_prev       = 1'b1;

    // Reset state
    #12;
    check("rst_rgb", 32'(rgb_out()), 32'h000);
    check("rst_hs", 32'(bus.vga_hsync), 32'd1);
    check("rst_vs", 32'(bus.vga_vsync), 32'd1);
    check("rst_fc", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Latency sweep, solid colour, row 10, hsync pulse 656..751
    for (int c = 0; c < 800; c++) begin
      bus.column = 10'(c);
      bus.hsync  = (c >= 656 && c < 752) ? 1'b0 : 1'b1;
      tick();
      if (c > 0) begin
        check($sformatf("lat_rgb_c%0d", c - 1), 32'(rgb_out()),
              (c - 1 < 640) ? 32'hA5C : 32'h000);
        check($sformatf("lat_hs_c%0d", c - 1), 32'(bus.vga_hsync), 32'(hs_prev));
      end
      hs_prev = bus.hsync;
    end
    bus.hsync = 1'b1;
    check("lat_fc", 32'(bus.frame_cnt), 32'd0);

    // Held frame start: pixel 0 uses the old mode, the rest the new one
    bus.mode   = 2'd1;
    bus.row    = 10'd0;
    bus.column = 10'd0;
    tick();
    tick();
    check("fs_old_mode", 32'(rgb_out()), 32'hA5C);
    tick();
    check("fs_new_mode", 32'(rgb_out()), 32'hFFF);
    tick();
    tick();
    check("fs_held_fc", 32'(bus.frame_cnt), 32'd1);

    // Colour bars
    pix(79,  5, "bar_79",  12'hFFF);
    pix(80,  5, "bar_80",  12'hFF0);
    pix(160, 5, "bar_160", 12'h0FF);
    pix(240, 5, "bar_240", 12'h0F0);
    pix(320, 5, "bar_320", 12'hF0F);
    pix(400, 5, "bar_400", 12'hF00);
    pix(559, 5, "bar_559", 12'h00F);
    pix(560, 5, "bar_560", 12'h000);
    pix(639, 5, "bar_639", 12'h000);

    // Mode latch: back to solid, then request border mid-frame
    bus.mode = 2'd0;
    pix(0, 0, "fs_bar_pixel", 12'hFFF);
    check("fc_2", 32'(bus.frame_cnt), 32'd2);
    pix(300, 50, "solid_r50", 12'hA5C);
    bus.mode = 2'd3;
    pix(320, 100, "latch_r100", 12'hA5C);
    pix(0, 240, "latch_r240", 12'hA5C);
    pix(0, 0, "fs_solid_pixel", 12'hA5C);
    check("fc_3", 32'(bus.frame_cnt), 32'd3);

    // Border: row 240 entirely white
    bus.row = 10'd240;
    for (int c = 0; c <= 640; c++) begin
      bus.column = 10'(c);
      tick();
      if (c > 0) check($sformatf("row240_c%0d", c - 1), 32'(rgb_out()), 32'hFFF);
    end
    pix(5,   5,   "brd_inner",  12'h000);
    pix(0,   17,  "brd_left",   12'hFFF);
    pix(639, 17,  "brd_right",  12'hFFF);
    pix(320, 17,  "brd_vmid",   12'hFFF);
    pix(17,  479, "brd_bottom", 12'hFFF);
    pix(17,  0,   "brd_top",    12'hFFF);
    pix(638, 478, "brd_inner2", 12'h000);
    pix(640, 240, "brd_hblank", 12'h000);

    // Checkerboard and frame counter wrap
    bus.mode = 2'd2;
    pix(0, 0, "fs_border_pixel", 12'hFFF);
    check("fc_4", 32'(bus.frame_cnt), 32'd4);
    for (int f = 0; f < 252; f++) next_frame();
    check("fc_wrap", 32'(bus.frame_cnt), 32'd0);
    pix(32, 0,  "chk_fc0_c32",     12'hFFF);
    pix(16, 0,  "chk_fc0_c16",     12'h000);
    pix(32, 32, "chk_fc0_c32_r32", 12'h000);
    pix(0,  0,  "chk_fs_fc0",      12'h000);
    check("fc_1", 32'(bus.frame_cnt), 32'd1);
    for (int f = 0; f < 31; f++) next_frame();
    check("fc_32", 32'(bus.frame_cnt), 32'd32);
    pix(0,  0, "chk_fc32_c0",  12'hFFF);
    check("fc_32_held", 32'(bus.frame_cnt), 32'd32);
    pix(31, 0, "chk_fc32_c31", 12'hFFF);
    pix(32, 0, "chk_fc32_c32", 12'h000);

    // rgb_en gating on row 0
    pix(10, 0, "en1_c10", 12'hFFF);
    bus.rgb_en = 1'b0;
    pix(10, 0, "en0_c10", 12'h000);
    bus.rgb_en = 1'b1;

    // Syncs through, then asynchronous reset mid-line
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    pix(10, 0, "pre_rst_rgb", 12'hFFF);
    check("pre_rst_hs", 32'(bus.vga_hsync), 32'd0);
    check("pre_rst_vs", 32'(bus.vga_vsync), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb_out()), 32'h000);
    check("mid_rst_hs", 32'(bus.vga_hsync), 32'd1);
    check("mid_rst_vs", 32'(bus.vga_vsync), 32'd1);
    check("mid_rst_fc", 32'(bus.frame_cnt), 32'd0);
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.mode = 2'd3;
    pix(320, 17, "post_rst_solid", 12'hA5C);
    check("post_rst_fc", 32'(bus.frame_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
